img_sum_vote: RTL

//  Parametrised successor to the face-detection tile merger. Accepts per-core detection tiles (1 bit/pixel,
//  row-major) over a valid/ready stream and places each tile at its grid offset in an IMG_SIZE x IMG_SIZE map.

---
 rtl/img_sum_vote.sv | 119 +++++++++++
 1 files changed

// File: rtl/img_sum_vote.sv
// img_sum_vote: merges 1-bit detection tiles into an IMG_SIZE x IMG_SIZE map with saturating per-pixel votes,
// then streams the thresholded mask out one pixel per valid/ready handshake.
module img_sum_vote #(
    parameter int IMG_SIZE = 64,
    parameter int GRID = 6,
    parameter int STRIDE = 8,
    parameter int TILE_W = 24,
    parameter int CNT_W = 3,
    localparam int ID_W = $clog2(GRID*GRID)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_signal,
    input  logic [CNT_W-1:0] thresh,
    input  logic             tile_valid,
    output logic             tile_ready,
    input  logic [ID_W-1:0]  tile_id,
    input  logic             tile_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             out_signal,
    output logic             tile_err
);
    localparam int N = IMG_SIZE*IMG_SIZE;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(TILE_W);
    localparam int TDW = $clog2(GRID*GRID+1);
    localparam logic [AW-1:0] PIX_LAST = AW'(N-1);
    localparam logic [RW-1:0] RC_LAST = RW'(TILE_W-1);
    localparam logic [TDW-1:0] TD_LAST = TDW'(GRID*GRID-1);
    localparam logic [ID_W:0] N_TILES = (ID_W+1)'(GRID*GRID);
    localparam logic [CNT_W-1:0] SAT = '1;
    localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_ACCUM = 3'd2, S_DUMP = 3'd3, S_DONE = 3'd4;

    logic [2:0] state;
    logic [AW-1:0] pix;
    logic [RW-1:0] r, c;
    logic [TDW-1:0] tiles_done;
    logic [CNT_W-1:0] th;
    logic [CNT_W-1:0] mem [N];
    logic [31:0] tx, ty;
    logic [AW-1:0] acc_addr;
    logic [CNT_W-1:0] acc_old;
    logic start, beat, id_ok, tile_end;

    assign start = in_signal && (state == S_IDLE || state == S_DONE);
    assign tile_ready = state == S_ACCUM;
    assign beat = tile_ready && tile_valid;
    assign id_ok = {1'b0, tile_id} < N_TILES;
    assign tile_end = r == RC_LAST && c == RC_LAST;
    assign tx = 32'(tile_id) % 32'(GRID);
    assign ty = 32'(tile_id) / 32'(GRID);
    assign acc_addr = AW'((ty*STRIDE + 32'(r))*IMG_SIZE + tx*STRIDE + 32'(c));
    assign acc_old = mem[acc_addr];

    // Asynchronous read lets back-to-back beats to one pixel see the previous write
    always_ff @(posedge clk)
        if (state == S_CLEAR)
            mem[pix] <= '0;
        else if (beat && id_ok && tile_bit)
            mem[acc_addr] <= acc_old == SAT ? SAT : acc_old + CNT_W'(1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= S_IDLE;
            pix <= '0;
            r <= '0;
            c <= '0;
            tiles_done <= '0;
            th <= '0;
            out_valid <= 1'b0;
            out_bit <= 1'b0;
            out_last <= 1'b0;
            out_signal <= 1'b0;
            tile_err <= 1'b0;
        end else if (start) begin
            state <= S_CLEAR;
            th <= thresh;
            tile_err <= 1'b0;
            out_signal <= 1'b0;
            pix <= '0;
            r <= '0;
            c <= '0;
            tiles_done <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    pix <= pix == PIX_LAST ? '0 : pix + AW'(1);
                    if (pix == PIX_LAST) state <= S_ACCUM;
                end
                S_ACCUM: if (beat) begin
                    c <= c == RC_LAST ? '0 : c + RW'(1);
                    if (c == RC_LAST) r <= r == RC_LAST ? '0 : r + RW'(1);
                    if (!id_ok) tile_err <= 1'b1;
                    if (id_ok && tile_end) begin
                        tiles_done <= tiles_done + TDW'(1);
                        if (tiles_done == TD_LAST) state <= S_DUMP;
                    end
                end
                S_DUMP: if (!out_valid || out_ready) begin
                    if (out_valid && out_last) begin
                        out_valid <= 1'b0;
                        out_bit <= 1'b0;
                        out_last <= 1'b0;
                        out_signal <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        out_valid <= 1'b1;
                        out_bit <= mem[pix] >= th;
                        out_last <= pix == PIX_LAST;
                        pix <= pix + AW'(1);
                    end
                end
                default: ;
            endcase
        end
endmodule
